mem_port_arbiter: RTL and testbench

//  Shares the single-port word memory between the instruction-fetch port (I, read-only)
//  and the load/store data port (D, read/write) of the MIPS32 pipeline.

---
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 tb/tb_mem_port_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM-stage requesters, the word memory and mem_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface mem_port_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [DW-1:0] i_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;

    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    logic          busy;
    logic          owner;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, m_en, m_we, m_addr, m_wdata, busy, owner
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, m_en, m_we, m_addr, m_wdata, busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the instruction-fetch (I) and load/store (D) ports.
// D has fixed priority; a starvation counter forces an I grant after STARVE_MAX losses.
module mem_port_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk1,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [2:0]    lat;
    logic [3:0]    starve;

    logic          i_ack_q;
    logic          d_ack_q;
    logic [DW-1:0] i_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          m_en_q;
    logic          m_we_q;
    logic [AW-1:0] m_addr_q;
    logic [DW-1:0] m_wdata_q;
    logic          busy_q;
    logic          owner_q;

    logic          grant_i;

    // I wins only when D is absent or I has lost STARVE_MAX arbitrations in a row.
    assign grant_i = bus.i_req && (!bus.d_req || (starve == 4'(STARVE_MAX)));

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat       <= '0;
            starve    <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            busy_q    <= 1'b0;
            owner_q   <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low every edge so each branch only raises them for one cycle.
            m_en_q  <= 1'b0;
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        state  <= WAIT;
                        lat    <= 3'(MEM_LAT);
                        m_en_q <= 1'b1;
                        busy_q <= 1'b1;
                        if (grant_i) begin
                            owner_q  <= 1'b0;
                            m_we_q   <= 1'b0;
                            m_addr_q <= bus.i_addr;
                            starve   <= '0;
                        end else begin
                            owner_q   <= 1'b1;
                            m_we_q    <= bus.d_we;
                            m_addr_q  <= bus.d_addr;
                            m_wdata_q <= bus.d_wdata;
                            // D can only beat a pending I while starve < STARVE_MAX, so this saturates.
                            starve    <= bus.i_req ? starve + 4'd1 : 4'd0;
                        end
                    end else begin
                        starve <= '0;
                    end
                end

                WAIT: begin
                    lat <= lat - 3'd1;
                    if (lat == 3'd1) begin
                        state <= RESP;
                        if (!owner_q) begin
                            i_ack_q   <= 1'b1;
                            i_rdata_q <= bus.m_rdata;
                        end else begin
                            d_ack_q <= 1'b1;
                            if (!m_we_q) d_rdata_q <= bus.m_rdata;
                        end
                    end
                end

                RESP: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.i_ack   = i_ack_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.m_en    = m_en_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.busy    = busy_q;
    assign bus.owner   = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SM = 4;

    logic clk1 = 1'b0;
    logic rst_n;
    always #5 clk1 = ~clk1;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus3 ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .STARVE_MAX(SM)) dut1 (
        .clk1(clk1), .rst_n(rst_n), .bus(bus1));
    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3), .STARVE_MAX(SM)) dut3 (
        .clk1(clk1), .rst_n(rst_n), .bus(bus3));

    // Memory models: latency 1 reads combinationally, latency 3 through two registers.
    logic [DW-1:0] mem1 [1024];
    logic [DW-1:0] mem3 [1024];
    logic [DW-1:0] p0, p1;
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;

    always @(posedge clk1) begin
        if (bd_we) begin
            mem1[bd_addr] <= bd_data;
            mem3[bd_addr] <= bd_data;
        end
        if (bus1.m_en && bus1.m_we) mem1[bus1.m_addr] <= bus1.m_wdata;
        if (bus3.m_en && bus3.m_we) mem3[bus3.m_addr] <= bus3.m_wdata;
        p0 <= mem3[bus3.m_addr];
        p1 <= p0;
    end
    assign bus1.m_rdata = mem1[bus1.m_addr];
    assign bus3.m_rdata = p1;

    int            n_cmp;
    int            n_bad;
    logic [DW-1:0] ref_mem [16];

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic idle_inputs();
        bus1.i_req = 1'b0; bus1.i_addr = '0; bus1.d_req = 1'b0;
        bus1.d_we = 1'b0; bus1.d_addr = '0; bus1.d_wdata = '0;
        bus3.i_req = 1'b0; bus3.i_addr = '0; bus3.d_req = 1'b0;
        bus3.d_we = 1'b0; bus3.d_addr = '0; bus3.d_wdata = '0;
    endtask

    task automatic bd_write(input logic [3:0] a, input logic [DW-1:0] v);
        bd_we   = 1'b1;
        bd_addr = AW'(a);
        bd_data = v;
        tick();
        bd_we = 1'b0;
        ref_mem[a] = v;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({bus1.i_ack, bus1.d_ack, bus1.m_en, bus1.m_we, bus1.busy, bus1.owner} !== 6'b0 ||
            bus1.i_rdata !== '0 || bus1.d_rdata !== '0 || bus1.m_addr !== '0 || bus1.m_wdata !== '0) begin
            n_bad++;
            $display("FAIL reset_init got ctl=%b m_addr=%h i_rdata=%h exp all 0",
                {bus1.i_ack, bus1.d_ack, bus1.m_en, bus1.m_we, bus1.busy, bus1.owner},
                bus1.m_addr, bus1.i_rdata);
        end
        @(negedge clk1);
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++)
            bd_write(4'(a), (a == 5) ? 32'hDEADBEEF : 32'hA5A50000 + 32'(a));

        bus1.i_req  = 1'b1;
        bus1.i_addr = 10'd5;
        tick();
        n_cmp++;
        if (bus1.m_en !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_pre_grant got m_en=%b exp 1", bus1.m_en);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus1.i_ack, bus1.d_ack, bus1.m_en, bus1.m_we, bus1.busy, bus1.owner} !== 6'b0 ||
            bus1.i_rdata !== '0 || bus1.d_rdata !== '0 || bus1.m_addr !== '0 || bus1.m_wdata !== '0) begin
            n_bad++;
            $display("FAIL reset_midop got ctl=%b m_addr=%h i_rdata=%h exp all 0",
                {bus1.i_ack, bus1.d_ack, bus1.m_en, bus1.m_we, bus1.busy, bus1.owner},
                bus1.m_addr, bus1.i_rdata);
        end
        bus1.i_req = 1'b0;
        @(negedge clk1);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++;
            if ({bus1.i_ack, bus1.m_en, bus1.busy} !== 3'b000) begin
                n_bad++;
                $display("FAIL reset_no_ack cyc %0d got ack/en/busy=%b exp 000", c,
                    {bus1.i_ack, bus1.m_en, bus1.busy});
            end
        end
    endtask

    task automatic test_single_read();
        bus1.i_req  = 1'b1;
        bus1.i_addr = 10'd5;
        tick();
        n_cmp++;
        if ({bus1.m_en, bus1.m_we, bus1.busy, bus1.i_ack, bus1.m_addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 10'd5}) begin
            n_bad++;
            $display("FAIL read_grant got en/we/busy/ack=%b addr=%0d exp 1010 addr=5",
                {bus1.m_en, bus1.m_we, bus1.busy, bus1.i_ack}, bus1.m_addr);
        end
        bus1.i_req = 1'b0;
        tick();
        n_cmp++;
        if ({bus1.m_en, bus1.i_ack, bus1.busy} !== 3'b011) begin
            n_bad++;
            $display("FAIL read_ack got en/ack/busy=%b exp 011", {bus1.m_en, bus1.i_ack, bus1.busy});
        end
        n_cmp++;
        if (bus1.i_rdata !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL read_data got %h exp deadbeef", bus1.i_rdata);
        end
        tick();
        n_cmp++;
        if ({bus1.i_ack, bus1.busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL read_done got ack/busy=%b exp 00", {bus1.i_ack, bus1.busy});
        end
    endtask

    task automatic test_priority();
        bus1.i_req = 1'b1; bus1.i_addr = 10'd3;
        bus1.d_req = 1'b1; bus1.d_we = 1'b1; bus1.d_addr = 10'd7; bus1.d_wdata = 32'h12345678;
        tick();
        n_cmp++;
        if ({bus1.m_en, bus1.m_we, bus1.owner, bus1.m_addr, bus1.m_wdata} !==
            {1'b1, 1'b1, 1'b1, 10'd7, 32'h12345678}) begin
            n_bad++;
            $display("FAIL prio_d_grant got en/we/own=%b addr=%0d wdata=%h exp 111 addr=7 wdata=12345678",
                {bus1.m_en, bus1.m_we, bus1.owner}, bus1.m_addr, bus1.m_wdata);
        end
        tick();
        n_cmp++;
        if ({bus1.d_ack, bus1.i_ack} !== 2'b10) begin
            n_bad++;
            $display("FAIL prio_d_ack got d/i ack=%b exp 10", {bus1.d_ack, bus1.i_ack});
        end
        bus1.d_req = 1'b0; bus1.d_we = 1'b0;
        ref_mem[7] = 32'h12345678;
        tick();
        n_cmp++;
        if (bus1.m_en !== 1'b0) begin
            n_bad++;
            $display("FAIL prio_resp_nogrant got m_en=%b exp 0", bus1.m_en);
        end
        tick();
        n_cmp++;
        if ({bus1.m_en, bus1.m_we, bus1.owner, bus1.m_addr} !== {1'b1, 1'b0, 1'b0, 10'd3}) begin
            n_bad++;
            $display("FAIL prio_i_grant got en/we/own=%b addr=%0d exp 100 addr=3",
                {bus1.m_en, bus1.m_we, bus1.owner}, bus1.m_addr);
        end
        tick();
        n_cmp++;
        if (bus1.i_ack !== 1'b1 || bus1.i_rdata !== ref_mem[3]) begin
            n_bad++;
            $display("FAIL prio_i_ack got ack=%b data=%h exp 1 %h", bus1.i_ack, bus1.i_rdata, ref_mem[3]);
        end
        bus1.i_addr = 10'd7;
        tick();
        tick();
        tick();
        bus1.i_req = 1'b0;
        n_cmp++;
        if (bus1.i_ack !== 1'b1 || bus1.i_rdata !== 32'h12345678) begin
            n_bad++;
            $display("FAIL prio_store_readback got ack=%b data=%h exp 1 12345678", bus1.i_ack, bus1.i_rdata);
        end
        tick();
    endtask

    task automatic test_starvation();
        logic owners [$];
        bus1.i_req = 1'b1; bus1.i_addr = 10'd2;
        bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 10'd4;
        for (int c = 0; c < 60 && owners.size() < 10; c++) begin
            tick();
            if (bus1.m_en === 1'b1) owners.push_back(bus1.owner);
        end
        idle_inputs();
        n_cmp++;
        if (owners.size() != 10) begin
            n_bad++;
            $display("FAIL starve_timeout got %0d grants exp 10", owners.size());
        end
        foreach (owners[g]) begin
            n_cmp++;
            if (owners[g] !== ((g % (SM + 1)) != SM)) begin
                n_bad++;
                $display("FAIL starve_grant_%0d got owner=%b exp %b", g, owners[g], (g % (SM + 1)) != SM);
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_drop();
        int cnt_en = 0;
        int cnt_ack = 0;
        bus1.i_req = 1'b1; bus1.i_addr = 10'd9;
        tick();
        n_cmp++;
        if (bus1.m_en !== 1'b1) begin
            n_bad++;
            $display("FAIL drop_grant got m_en=%b exp 1", bus1.m_en);
        end
        bus1.i_req = 1'b0;
        repeat (6) begin
            tick();
            cnt_en  += int'(bus1.m_en);
            cnt_ack += int'(bus1.i_ack);
        end
        n_cmp++;
        if (cnt_en != 0 || cnt_ack != 1) begin
            n_bad++;
            $display("FAIL drop_counts got extra_en=%0d acks=%0d exp 0 1", cnt_en, cnt_ack);
        end
        n_cmp++;
        if (bus1.busy !== 1'b0 || bus1.i_rdata !== ref_mem[9]) begin
            n_bad++;
            $display("FAIL drop_final got busy=%b data=%h exp 0 %h", bus1.busy, bus1.i_rdata, ref_mem[9]);
        end
    endtask

    task automatic test_back_to_back();
        int en_c [$];
        int ack_c [$];
        bus3.d_req = 1'b1; bus3.d_we = 1'b0; bus3.d_addr = 10'd5;
        for (int c = 0; c < 40 && ack_c.size() < 3; c++) begin
            tick();
            if (bus3.m_en === 1'b1) en_c.push_back(c);
            if (bus3.d_ack === 1'b1) begin
                ack_c.push_back(c);
                n_cmp++;
                if (bus3.d_rdata !== ref_mem[5]) begin
                    n_bad++;
                    $display("FAIL b2b_data got %h exp %h", bus3.d_rdata, ref_mem[5]);
                end
            end
        end
        bus3.d_req = 1'b0;
        n_cmp++;
        if (ack_c.size() != 3 || en_c.size() < 3) begin
            n_bad++;
            $display("FAIL b2b_timeout got %0d en %0d acks exp 3 3", en_c.size(), ack_c.size());
        end else begin
            for (int j = 0; j < 3; j++) begin
                n_cmp++;
                if (ack_c[j] - en_c[j] != 3) begin
                    n_bad++;
                    $display("FAIL b2b_latency_%0d got %0d exp 3", j, ack_c[j] - en_c[j]);
                end
            end
            for (int j = 0; j < 2; j++) begin
                n_cmp++;
                if (en_c[j+1] - en_c[j] != 5) begin
                    n_bad++;
                    $display("FAIL b2b_period_%0d got %0d exp 5", j, en_c[j+1] - en_c[j]);
                end
            end
        end
        repeat (6) tick();
    endtask

    // Transaction-level model: one access in flight, ack MEM_LAT after grant,
    // next grant no sooner than two edges after the ack, D-priority with starvation override.
    task automatic test_random();
        int            starve = 0;
        bit            pend = 1'b0;
        bit            pend_d = 1'b0;
        bit            pend_rd = 1'b0;
        int            ack_cyc = 0;
        int            next_ok = 0;
        logic [DW-1:0] exp_data = '0;
        logic          ei, ed, ewe, exp_en, win_d;
        logic [AW-1:0] eia, eda, ga;
        logic [DW-1:0] ewd;
        idle_inputs();
        for (int c = 0; c < 600; c++) begin
            ei = bus1.i_req; ed = bus1.d_req; ewe = bus1.d_we;
            eia = bus1.i_addr; eda = bus1.d_addr; ewd = bus1.d_wdata;
            tick();
            exp_en = !pend && (c >= next_ok) && (ei || ed);
            n_cmp++;
            if (bus1.m_en !== exp_en) begin
                n_bad++;
                $display("FAIL rnd_m_en cyc %0d got %b exp %b", c, bus1.m_en, exp_en);
            end
            if (exp_en) begin
                win_d = ed && !(ei && starve == SM);
                ga    = win_d ? eda : eia;
                n_cmp++;
                if ({bus1.owner, bus1.m_we, bus1.m_addr} !== {win_d, win_d && ewe, ga}) begin
                    n_bad++;
                    $display("FAIL rnd_grant cyc %0d got own/we=%b addr=%0d exp %b addr=%0d", c,
                        {bus1.owner, bus1.m_we}, bus1.m_addr, {win_d, win_d && ewe}, ga);
                end
                if (win_d && ewe) begin
                    n_cmp++;
                    if (bus1.m_wdata !== ewd) begin
                        n_bad++;
                        $display("FAIL rnd_wdata cyc %0d got %h exp %h", c, bus1.m_wdata, ewd);
                    end
                    ref_mem[ga[3:0]] = ewd;
                end
                starve   = (ei && win_d) ? starve + 1 : 0;
                pend     = 1'b1;
                pend_d   = win_d;
                pend_rd  = !(win_d && ewe);
                ack_cyc  = c + 1;
                exp_data = ref_mem[ga[3:0]];
            end
            if (pend && c == ack_cyc) begin
                n_cmp++;
                if ({bus1.i_ack, bus1.d_ack} !== (pend_d ? 2'b01 : 2'b10)) begin
                    n_bad++;
                    $display("FAIL rnd_ack cyc %0d got i/d=%b exp %b", c, {bus1.i_ack, bus1.d_ack},
                        pend_d ? 2'b01 : 2'b10);
                end
                if (pend_rd) begin
                    n_cmp++;
                    if ((pend_d ? bus1.d_rdata : bus1.i_rdata) !== exp_data) begin
                        n_bad++;
                        $display("FAIL rnd_rdata cyc %0d got %h exp %h", c,
                            pend_d ? bus1.d_rdata : bus1.i_rdata, exp_data);
                    end
                end
                pend    = 1'b0;
                next_ok = c + 2;
            end else begin
                n_cmp++;
                if ({bus1.i_ack, bus1.d_ack} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL rnd_spurious_ack cyc %0d got i/d=%b exp 00", c, {bus1.i_ack, bus1.d_ack});
                end
            end
            if (bus1.i_ack === 1'b1 || !bus1.i_req) begin
                bus1.i_req  = ($urandom_range(0, 2) != 0);
                bus1.i_addr = AW'($urandom_range(0, 15));
            end
            if (bus1.d_ack === 1'b1 || !bus1.d_req) begin
                bus1.d_req   = ($urandom_range(0, 2) != 0);
                bus1.d_we    = ($urandom_range(0, 1) != 0);
                bus1.d_addr  = AW'($urandom_range(0, 15));
                bus1.d_wdata = $urandom;
            end
        end
        idle_inputs();
        repeat (4) tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bd_we = 1'b0;
        bd_addr = '0;
        bd_data = '0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_priority();
        test_starvation();
        test_drop();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
